// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Opcodes, FSM state encoding and the PC step size.
package fetch_pkg;

   localparam logic [5:0] OP_HALT  = 6'b111111;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam int         PC_STEP  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   function automatic logic is_halt(input logic [5:0] opcode);
      return (opcode == OP_HALT);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's control, instruction-memory and datapath-side signals.
// master = fetch unit, slave = environment (memory, datapath, control).
interface instr_fetch_if #(
   parameter int ADDR_W = 32
);

   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              imem_rd;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic              busy;
   logic              halted;

   modport master (
      input  start, base_addr, imem_data, instr_ready, redirect, redirect_addr,
      output imem_rd, imem_addr, instr, instr_pc, instr_valid, busy, halted
   );

   modport slave (
      output start, base_addr, imem_data, instr_ready, redirect, redirect_addr,
      input  imem_rd, imem_addr, instr, instr_pc, instr_valid, busy, halted
   );

endinterface

// File: rtl/instr_fifo.sv
// Registered FIFO holding fetched {pc, instruction} pairs; head is read straight from storage.
// Supports push and pop in the same cycle even when full; clear has priority over both.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, 1-cycle-latency memory reads, FIFO buffering,
// redirect/flush and halt-on-opcode, feeding the datapath over valid/ready.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_fetch_if.master fetch_bus
);

   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int DATA_W = 32 + ADDR_W;

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic              r_inflight;

   logic [CNT_W-1:0]  w_fifo_count;
   logic [CNT_W-1:0]  w_occupancy;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic              w_active;
   logic              w_redirect;
   logic              w_resp_halt;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_fifo_wdata;
   logic [DATA_W-1:0] w_fifo_rdata;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return addr & ~(ADDR_W'(3));
   endfunction

   assign w_active     = (r_state == FETCH) || (r_state == DRAIN);
   assign w_redirect   = fetch_bus.redirect && w_active;
   assign w_resp_halt  = r_inflight && is_halt(fetch_bus.imem_data[31:26]);
   assign w_occupancy  = w_fifo_count + CNT_W'(r_inflight);

   // Counting the in-flight read as occupied guarantees its response always has a slot.
   assign w_issue      = (r_state == FETCH) && !fetch_bus.redirect && !w_fifo_full
                         && (w_occupancy < CNT_W'(DEPTH));
   assign w_push       = r_inflight && !w_resp_halt && !w_redirect;
   assign w_pop        = !w_fifo_empty && fetch_bus.instr_ready;
   assign w_fifo_wdata = {r_inflight_pc, fetch_bus.imem_data};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_pc          <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc          <= r_pc + ADDR_W'(PC_STEP);
            r_inflight_pc <= r_pc;
         end
         case (r_state)
            IDLE, HALTED: begin
               if (fetch_bus.start) begin
                  r_state <= FETCH;
                  r_pc    <= word_align(fetch_bus.base_addr);
               end
            end
            FETCH: begin
               if (fetch_bus.redirect) begin
                  r_pc       <= word_align(fetch_bus.redirect_addr);
                  r_inflight <= 1'b0;
               end else if (w_resp_halt) begin
                  // The read issued alongside the HALT response is dropped with it.
                  r_state    <= DRAIN;
                  r_inflight <= 1'b0;
               end
            end
            DRAIN: begin
               if (fetch_bus.redirect) begin
                  r_state    <= FETCH;
                  r_pc       <= word_align(fetch_bus.redirect_addr);
                  r_inflight <= 1'b0;
               end else if (w_fifo_empty) begin
                  r_state <= HALTED;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_redirect),
      .i_push  (w_push),
      .i_wdata (w_fifo_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign fetch_bus.imem_rd     = w_issue;
   assign fetch_bus.imem_addr   = r_pc;
   assign fetch_bus.instr       = w_fifo_rdata[31:0];
   assign fetch_bus.instr_pc    = w_fifo_rdata[DATA_W-1:32];
   assign fetch_bus.instr_valid = !w_fifo_empty;
   assign fetch_bus.busy        = w_active;
   assign fetch_bus.halted      = (r_state == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model plus a scoreboard of expected {pc, instr}
// pairs filled when fetching is started and drained as the datapath side accepts words.
module tb_instr_fetch;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   nChecks = 0;
   int   nErrors = 0;
   bit   haltEn  = 1'b0;
   exp_t expQ[$];

   instr_fetch_if #(.ADDR_W(32)) bus ();

   instr_fetch #(
      .DEPTH  (4),
      .ADDR_W (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fetch_bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (haltEn && a == 32'h0000_010C) return 32'hFC00_0000;
      if (a == 32'h0000_0100) return 32'h0022_3820;
      if (a == 32'h0000_0104) return 32'h0085_3020;
      return {6'b000000, a[25:0]};
   endfunction

   // Instruction memory with one cycle of read latency
   always @(posedge clk) begin
      if (!rst_n) bus.imem_data <= 32'h0;
      else if (bus.imem_rd) bus.imem_data <= memWord(bus.imem_addr);
   end

   task automatic pushExpected(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         expQ.push_back({base + 32'(4 * i), memWord(base + 32'(4 * i))});
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.redirect = 1'b0;
      bus.instr_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      expQ.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.base_addr = 32'h0;
      bus.redirect = 1'b0;
      bus.redirect_addr = 32'h0;
      bus.instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      nChecks++;
      if ({bus.imem_rd, bus.instr_valid, bus.busy, bus.halted} !== 4'b0000) begin
         nErrors++;
         $display("[TB] FAIL reset_flags rd/valid/busy/halted got %b want 0000",
                  {bus.imem_rd, bus.instr_valid, bus.busy, bus.halted});
      end
      nChecks++;
      if (bus.imem_addr !== 32'h0) begin
         nErrors++;
         $display("[TB] FAIL reset_imem_addr got %h want 00000000", bus.imem_addr);
      end
      nChecks++;
      if (bus.instr !== 32'h0) begin
         nErrors++;
         $display("[TB] FAIL reset_instr got %h want 00000000", bus.instr);
      end
      nChecks++;
      if (bus.instr_pc !== 32'h0) begin
         nErrors++;
         $display("[TB] FAIL reset_instr_pc got %h want 00000000", bus.instr_pc);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      exp_t e;
      pushExpected(32'h100, 8);
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         bus.start = (c == 0);
         bus.base_addr = 32'h100;
         bus.instr_ready = 1'b1;
         #1;
         if (c == 1) begin
            nChecks++;
            if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 32'h100) begin
               nErrors++;
               $display("[TB] FAIL stream_first_read rd=%b addr=%h want rd=1 addr=00000100",
                        bus.imem_rd, bus.imem_addr);
            end
         end
         if (c < 3) begin
            nChecks++;
            if (bus.instr_valid !== 1'b0) begin
               nErrors++;
               $display("[TB] FAIL stream_latency cycle %0d valid=%b want 0", c, bus.instr_valid);
            end
         end else begin
            nChecks++;
            if (bus.instr_valid !== 1'b1) begin
               nErrors++;
               $display("[TB] FAIL stream_valid cycle %0d valid=%b want 1", c, bus.instr_valid);
            end else begin
               e = expQ.pop_front();
               nChecks++;
               if (bus.instr_pc !== e.pc || bus.instr !== e.data) begin
                  nErrors++;
                  $display("[TB] FAIL stream_word pc=%h instr=%h want pc=%h instr=%h",
                           bus.instr_pc, bus.instr, e.pc, e.data);
               end
            end
         end
      end
      applyReset();
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   issues = 0;
      int   got = 0;
      pushExpected(32'h300, 8);
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         bus.start = (c == 0);
         bus.base_addr = 32'h300;
         bus.instr_ready = 1'b0;
         #1;
         if (bus.imem_rd === 1'b1) issues++;
         if (c >= 3) begin
            nChecks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== expQ[0].pc || bus.instr !== expQ[0].data) begin
               nErrors++;
               $display("[TB] FAIL bp_hold cycle %0d valid=%b pc=%h instr=%h want 1 %h %h",
                        c, bus.instr_valid, bus.instr_pc, bus.instr, expQ[0].pc, expQ[0].data);
            end
         end
      end
      nChecks++;
      if (issues != 4) begin
         nErrors++;
         $display("[TB] FAIL bp_buffered reads=%0d want 4", issues);
      end
      nChecks++;
      if (bus.imem_rd !== 1'b0) begin
         nErrors++;
         $display("[TB] FAIL bp_rd_full rd=%b want 0", bus.imem_rd);
      end
      for (int c = 0; c < 40 && got < 8; c++) begin
         @(negedge clk);
         bus.instr_ready = 1'b1;
         #1;
         if (bus.instr_valid === 1'b1) begin
            e = expQ.pop_front();
            got++;
            nChecks++;
            if (bus.instr_pc !== e.pc || bus.instr !== e.data) begin
               nErrors++;
               $display("[TB] FAIL bp_order pc=%h instr=%h want pc=%h instr=%h",
                        bus.instr_pc, bus.instr, e.pc, e.data);
            end
         end
      end
      nChecks++;
      if (got != 8) begin
         nErrors++;
         $display("[TB] FAIL bp_drain_timeout delivered=%0d want 8", got);
      end
      applyReset();
   endtask

   task automatic test_halt();
      exp_t e;
      haltEn = 1'b1;
      pushExpected(32'h100, 3);
      for (int c = 0; c < 40 && bus.halted !== 1'b1; c++) begin
         @(negedge clk);
         bus.start = (c == 0);
         bus.base_addr = 32'h100;
         bus.instr_ready = 1'b1;
         #1;
         if (bus.instr_valid === 1'b1) begin
            nChecks++;
            if (expQ.size() == 0) begin
               nErrors++;
               $display("[TB] FAIL halt_extra pc=%h instr=%h want no further words",
                        bus.instr_pc, bus.instr);
            end else begin
               e = expQ.pop_front();
               if (bus.instr_pc !== e.pc || bus.instr !== e.data) begin
                  nErrors++;
                  $display("[TB] FAIL halt_word pc=%h instr=%h want pc=%h instr=%h",
                           bus.instr_pc, bus.instr, e.pc, e.data);
               end
            end
         end
      end
      nChecks++;
      if (bus.halted !== 1'b1) begin
         nErrors++;
         $display("[TB] FAIL halt_timeout halted=%b want 1", bus.halted);
      end
      nChecks++;
      if (expQ.size() != 0) begin
         nErrors++;
         $display("[TB] FAIL halt_delivered remaining=%0d want 0", expQ.size());
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         nChecks++;
         if ({bus.imem_rd, bus.instr_valid, bus.busy, bus.halted} !== 4'b0001) begin
            nErrors++;
            $display("[TB] FAIL halt_idle rd/valid/busy/halted got %b want 0001",
                     {bus.imem_rd, bus.instr_valid, bus.busy, bus.halted});
         end
      end
      haltEn = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = 32'h200;
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      nChecks++;
      if (bus.halted !== 1'b0 || bus.busy !== 1'b1 || bus.imem_addr !== 32'h200) begin
         nErrors++;
         $display("[TB] FAIL halt_restart halted=%b busy=%b addr=%h want 0 1 00000200",
                  bus.halted, bus.busy, bus.imem_addr);
      end
      applyReset();
   endtask

   task automatic test_redirect();
      exp_t e;
      int   issues = 0;
      int   got = 0;
      for (int c = 0; c < 20 && issues < 4; c++) begin
         @(negedge clk);
         bus.start = (c == 0);
         bus.base_addr = 32'h100;
         bus.instr_ready = 1'b0;
         #1;
         if (bus.imem_rd === 1'b1) issues++;
      end
      @(negedge clk);
      bus.redirect = 1'b1;
      bus.redirect_addr = 32'h203;
      #1;
      nChecks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.imem_rd !== 1'b0) begin
         nErrors++;
         $display("[TB] FAIL redir_pre valid=%b pc=%h rd=%b want 1 00000100 0",
                  bus.instr_valid, bus.instr_pc, bus.imem_rd);
      end
      @(negedge clk);
      bus.redirect = 1'b0;
      bus.instr_ready = 1'b1;
      #1;
      nChecks++;
      if (bus.instr_valid !== 1'b0) begin
         nErrors++;
         $display("[TB] FAIL redir_flush valid=%b want 0", bus.instr_valid);
      end
      nChecks++;
      if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 32'h200) begin
         nErrors++;
         $display("[TB] FAIL redir_resume rd=%b addr=%h want 1 00000200", bus.imem_rd, bus.imem_addr);
      end
      pushExpected(32'h200, 4);
      for (int c = 0; c < 30 && got < 4; c++) begin
         @(negedge clk);
         bus.instr_ready = 1'b1;
         #1;
         if (bus.instr_valid === 1'b1) begin
            e = expQ.pop_front();
            got++;
            nChecks++;
            if (bus.instr_pc !== e.pc || bus.instr !== e.data) begin
               nErrors++;
               $display("[TB] FAIL redir_word pc=%h instr=%h want pc=%h instr=%h",
                        bus.instr_pc, bus.instr, e.pc, e.data);
            end
         end
      end
      nChecks++;
      if (got != 4) begin
         nErrors++;
         $display("[TB] FAIL redir_timeout delivered=%0d want 4", got);
      end
      applyReset();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   got = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.start = (c == 0);
         bus.base_addr = 32'h400;
         bus.instr_ready = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      nChecks++;
      if ({bus.imem_rd, bus.instr_valid, bus.busy, bus.halted} !== 4'b0000 ||
          bus.imem_addr !== 32'h0 || bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
         nErrors++;
         $display("[TB] FAIL rst_mid_outputs flags=%b addr=%h instr=%h pc=%h want all zero",
                  {bus.imem_rd, bus.instr_valid, bus.busy, bus.halted},
                  bus.imem_addr, bus.instr, bus.instr_pc);
      end
      pushExpected(32'h500, 3);
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk);
         bus.start = (c == 0);
         bus.base_addr = 32'h500;
         bus.instr_ready = 1'b1;
         #1;
         if (bus.instr_valid === 1'b1) begin
            e = expQ.pop_front();
            got++;
            nChecks++;
            if (bus.instr_pc !== e.pc || bus.instr !== e.data) begin
               nErrors++;
               $display("[TB] FAIL rst_mid_word pc=%h instr=%h want pc=%h instr=%h",
                        bus.instr_pc, bus.instr, e.pc, e.data);
            end
         end
      end
      nChecks++;
      if (got != 3) begin
         nErrors++;
         $display("[TB] FAIL rst_mid_timeout delivered=%0d want 3", got);
      end
      applyReset();
   endtask

   task automatic test_wrap();
      exp_t e;
      int   got = 0;
      pushExpected(32'hFFFF_FFF8, 3);
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk);
         bus.start = (c == 0);
         bus.base_addr = 32'hFFFF_FFF8;
         bus.instr_ready = 1'b1;
         #1;
         if (bus.instr_valid === 1'b1) begin
            e = expQ.pop_front();
            got++;
            nChecks++;
            if (bus.instr_pc !== e.pc || bus.instr !== e.data) begin
               nErrors++;
               $display("[TB] FAIL wrap_word pc=%h instr=%h want pc=%h instr=%h",
                        bus.instr_pc, bus.instr, e.pc, e.data);
            end
         end
      end
      nChecks++;
      if (got != 3) begin
         nErrors++;
         $display("[TB] FAIL wrap_timeout delivered=%0d want 3", got);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_halt();
      test_redirect();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
